cordic_polar2cart_iter: RTL and testbench
=========================================

Name: cordic_polar2cart_iter

Overview:
Iterative (non-pipelined) CORDIC in rotation mode. Converts polar input (mag, theta) to cartesian output (x, y), which is the inverse of the vectoring path.
One shared shift-add datapath is reused for ITER cycles under a small FSM, trading throughput for area. It is used in low-rate control and calibration paths.
Input and output use valid/ready handshakes and the same angle format as the vectoring block.

Parameters:
XY_W, 16, signed width of mag, x_out and y_out.
ANGLE_W, 32, width of theta as a signed binary angle; 2^(ANGLE_W-1) = pi.
ITER, 16, number of micro-rotations; legal range 1 to XY_W+GUARD.
GUARD, 3, LSB guard bits in the internal datapath.
GAIN_COMP, 1, nonzero applies 1/K scaling (KINV_Q15 >>> KINV_SHIFT) to the outputs.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input request
in_ready  out  1  block can accept an input this cycle
mag  in  XY_W  signed magnitude
theta  in  ANGLE_W  signed binary angle
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
x_out  out  XY_W  signed mag*cos(theta), saturated
y_out  out  XY_W  signed mag*sin(theta), saturated

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset state:
  - state = IDLE, iteration counter = 0.
  - out_valid = 0, x_out = 0, y_out = 0.
  - in_ready = 1 in the first cycle after reset.
  - A reset in any state, including mid-RUN, discards the operation in flight.
- FSM states:
  - IDLE -> RUN on accept.
  - RUN -> FIN after ITER iterations.
  - FIN -> DONE unconditionally.
  - DONE -> IDLE on out_ready && !in_valid.
  - DONE -> RUN on out_ready && in_valid (back-to-back accept).
  - DONE -> DONE while out_ready = 0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready = 0 in RUN and FIN.
- accept = in_valid && in_ready.
- Load on accept (quadrant fold). XYI = XY_W+GUARD; internal x/y are XYI+1 bits signed. Let m = sign-extend(mag) << GUARD.
  - If theta > +pi/2: x = -m, y = 0, z = theta - pi.
  - If theta < -pi/2: x = -m, y = 0, z = theta + pi.
  - Otherwise: x = m, y = 0, z = theta.
  - theta = -pi (most negative code) folds to z = 0, x = -m.
  - Exactly +/-pi/2 is not folded.
  - Counter i = 0.
- RUN, one micro-rotation per cycle, for i = 0 to ITER-1:
  - d = +1 if z >= 0, else -1.
  - x <= x - d*(y >>> i); y <= y + d*(x >>> i); z <= z - d*atan_lut(i).
  - All updates use pre-edge values. Shifts are arithmetic.
  - Leave RUN on the edge where i = ITER-1.
- FIN: register the outputs.
  - If GAIN_COMP != 0, scale each of x and y by KINV_Q15 with a full-width signed product, then >>> KINV_SHIFT.
  - Then >>> GUARD (truncating), then saturate to [-2^(XY_W-1), 2^(XY_W-1)-1].
  - Set out_valid = 1 on entry to DONE.
- Latency: accept on edge E0 gives out_valid = 1 after edge E(ITER+1), i.e. 17 cycles for ITER = 16. Minimum initiation interval is ITER+2 cycles.
- While out_valid && !out_ready: x_out, y_out and out_valid hold stable.
- out_valid falls on the edge after the output handshake unless a new accept occurs in the same cycle. In that case out_valid still falls and RUN restarts.
- Negative mag is legal and yields the opposite vector. mag = -2^(XY_W-1) must not overflow internally; the extra sign bit covers the growth of K.
- in_valid in a non-ready state is ignored. The source must hold it, per the standard valid/ready rule.

Decomposition:
- cordic_pkg (existing), shared with the vectoring block:
  - KINV_Q15 and KINV_SHIFT.
  - The atan table as function atan_lut(i, ANGLE_W) returning round(atan(2^-i) * 2^(ANGLE_W-1)/pi).
- New package items: state enum cordic_iter_state_t (IDLE, RUN, FIN, DONE).
- Sub-module cordic_preproc_rot: combinational quadrant fold (mag, theta -> x0, y0, z0). Kept separate so a pipelined rotator can reuse it.
- Top module holds the FSM, counter, datapath registers and output scaling/saturation.

Test Plan:
- GAIN_COMP=1, mag=16384, theta=0 -> x_out within 16384+/-4, y_out within 0+/-4; out_valid rises exactly 17 cycles after accept.
- mag=16384, theta=0x4000_0000 (+pi/2) -> x_out 0+/-4, y_out 16384+/-4. theta=0x2000_0000 (pi/4) -> x_out and y_out each 11585+/-4.
- mag=16384, theta=0x8000_0000 (-pi) -> x_out -16384+/-4, y_out 0+/-4. theta=0xA000_0000 (-3pi/4) -> x_out and y_out each -11585+/-4.
- GAIN_COMP=0, mag=32767, theta=0 -> x_out = 32767 (saturated), y_out 0+/-4. mag=-32768, theta=0 -> x_out = -32768.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 in the same cycle -> new accept, out_valid=0 next cycle, next result 17 cycles later.
- Assert rst for 1 cycle at RUN iteration 5 -> next cycle out_valid=0, in_ready=1. The aborted operation never produces an output; a fresh request completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, arctangent table and iterative-rotator state encoding.
package cordic_pkg;

  localparam int KINV_Q15   = 19898;
  localparam int unsigned KINV_SHIFT = 15;
  localparam int unsigned KINV_W     = 17;

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} cordic_iter_state_t;

  // round(atan(2^-i) * 2^(angle_w-1) / pi); table is held at 32-bit angle precision
  function automatic logic [63:0] atan_lut(input int unsigned i, input int unsigned angle_w);
    logic [31:0] t;
    logic [63:0] r;
    case (i)
      0:  t = 32'h2000_0000;
      1:  t = 32'h12E4_051E;
      2:  t = 32'h09FB_385B;
      3:  t = 32'h0511_11D4;
      4:  t = 32'h028B_0D43;
      5:  t = 32'h0145_D7E1;
      6:  t = 32'h00A2_F61E;
      7:  t = 32'h0051_7C55;
      8:  t = 32'h0028_BE53;
      9:  t = 32'h0014_5F2F;
      10: t = 32'h000A_2F98;
      11: t = 32'h0005_17CC;
      12: t = 32'h0002_8BE6;
      13: t = 32'h0001_45F3;
      14: t = 32'h0000_A2FA;
      15: t = 32'h0000_517D;
      16: t = 32'h0000_28BE;
      17: t = 32'h0000_145F;
      18: t = 32'h0000_0A30;
      19: t = 32'h0000_0518;
      20: t = 32'h0000_028C;
      21: t = 32'h0000_0146;
      22: t = 32'h0000_00A3;
      23: t = 32'h0000_0051;
      24: t = 32'h0000_0029;
      25: t = 32'h0000_0014;
      26: t = 32'h0000_000A;
      27: t = 32'h0000_0005;
      28: t = 32'h0000_0003;
      29: t = 32'h0000_0001;
      30: t = 32'h0000_0001;
      default: t = 32'h0000_0000;
    endcase
    if (angle_w >= 32) begin
      r = 64'(t) << (angle_w - 32);
    end else begin
      r = (64'(t) + (64'd1 << (31 - angle_w))) >> (32 - angle_w);
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_preproc_rot.sv
// Quadrant fold for rotation mode: brings theta into [-pi/2, pi/2] by negating the start vector.
module cordic_preproc_rot
  import cordic_pkg::*;
#(
  parameter int unsigned XY_W    = 16,
  parameter int unsigned ANGLE_W = 32,
  parameter int unsigned GUARD   = 3
) (
  input  logic signed [XY_W-1:0]     mag,
  input  logic signed [ANGLE_W-1:0]  theta,
  output logic signed [XY_W+GUARD:0] x0_c,
  output logic signed [XY_W+GUARD:0] y0_c,
  output logic        [ANGLE_W-1:0]  z0_c
);

  localparam int unsigned DW = XY_W + GUARD + 1;
  localparam logic signed [ANGLE_W-1:0] HALF_PI     = ANGLE_W'(1) << (ANGLE_W - 2);
  localparam logic signed [ANGLE_W-1:0] NEG_HALF_PI = -HALF_PI;

  logic signed [DW-1:0] m;

  assign m = DW'(mag) <<< GUARD;

  // Adding pi modulo 2^ANGLE_W is a flip of the angle sign bit
  always_comb begin
    x0_c = m;
    y0_c = '0;
    z0_c = theta;
    if ((theta > HALF_PI) || (theta < NEG_HALF_PI)) begin
      x0_c = -m;
      z0_c = {~theta[ANGLE_W-1], theta[ANGLE_W-2:0]};
    end
  end

endmodule

// File: rtl/cordic_polar2cart_iter.sv
// Iterative rotation-mode CORDIC: polar (mag, theta) to cartesian (x, y), one micro-rotation per cycle.
module cordic_polar2cart_iter
  import cordic_pkg::*;
#(
  parameter int unsigned XY_W      = 16,
  parameter int unsigned ANGLE_W   = 32,
  parameter int unsigned ITER      = 16,
  parameter int unsigned GUARD     = 3,
  parameter int unsigned GAIN_COMP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [XY_W-1:0]    mag,
  input  logic signed [ANGLE_W-1:0] theta,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [XY_W-1:0]    x_out,
  output logic signed [XY_W-1:0]    y_out
);

  localparam int unsigned DW    = XY_W + GUARD + 1;
  localparam int unsigned PW    = DW + KINV_W;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (XY_W - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  cordic_iter_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [DW-1:0] x_q, y_q, x0_c, y0_c, x_sh, y_sh;
  logic [ANGLE_W-1:0] z_q, z0_c, atan_c;
  logic               accept;

  cordic_preproc_rot #(
    .XY_W   (XY_W),
    .ANGLE_W(ANGLE_W),
    .GUARD  (GUARD)
  ) u_preproc (
    .mag  (mag),
    .theta(theta),
    .x0_c (x0_c),
    .y0_c (y0_c),
    .z0_c (z0_c)
  );

  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_c = ANGLE_W'(atan_lut(32'(cnt_q), ANGLE_W));
  assign accept = in_valid && in_ready;

  // Optional 1/K gain, drop guard bits, clamp to the output range
  function automatic logic signed [XY_W-1:0] scale_sat(input logic signed [DW-1:0] v);
    logic signed [PW-1:0] p;
    logic signed [XY_W-1:0] r;
    p = PW'(v);
    if (GAIN_COMP != 0) begin
      p = (p * PW'(KINV_Q15)) >>> KINV_SHIFT;
    end
    p = p >>> GUARD;
    if (p > SAT_MAX) begin
      r = SAT_MAX[XY_W-1:0];
    end else if (p < SAT_MIN) begin
      r = SAT_MIN[XY_W-1:0];
    end else begin
      r = p[XY_W-1:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIN: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? RUN : IDLE;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared shift-add datapath and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        x_q <= x0_c;
        y_q <= y0_c;
        z_q <= z0_c;
      end else if (state_q == RUN) begin
        if (!z_q[ANGLE_W-1]) begin
          x_q <= x_q - y_sh;
          y_q <= y_q + x_sh;
          z_q <= z_q - atan_c;
        end else begin
          x_q <= x_q + y_sh;
          y_q <= y_q - x_sh;
          z_q <= z_q + atan_c;
        end
      end
      if (state_q == FIN) begin
        x_out     <= scale_sat(x_q);
        y_out     <= scale_sat(y_q);
        out_valid <= 1'b1;
      end else if ((state_q == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_polar2cart_iter.sv
// Scoreboard bench: gain-compensated and raw-gain instances driven in lockstep, checked against real-valued trig.
module tb_cordic_polar2cart_iter;

  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] mag = '0;
  logic signed [31:0] theta = '0;

  logic in_ready_c, out_valid_c, in_ready_n, out_valid_n;
  logic signed [15:0] x_c, y_c, x_n, y_n;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rdy_mode = 1;
  real kgain = 1.0;

  typedef struct {
    int  m;
    int  t;
    real xc;
    real yc;
    real xn;
    real yn;
    int  acc;
  } exp_t;

  exp_t sb[$];

  cordic_polar2cart_iter #(.GAIN_COMP(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .mag(mag), .theta(theta), .out_valid(out_valid_c), .out_ready(out_ready),
    .x_out(x_c), .y_out(y_c)
  );

  cordic_polar2cart_iter #(.GAIN_COMP(0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .mag(mag), .theta(theta), .out_valid(out_valid_n), .out_ready(out_ready),
    .x_out(x_n), .y_out(y_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real clamp(input real v);
    if (v > 32767.0) return 32767.0;
    if (v < -32768.0) return -32768.0;
    return v;
  endfunction

  task automatic check_eq(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input real req, input real tol);
    real d;
    total++;
    d = $itor(act) - req;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0.2f +/- %0.1f (t=%0t)", name, act, req, tol, $time);
    end
  endtask

  task automatic send(input int m, input int t);
    exp_t e;
    int n;
    real a;
    mag = 16'(m);
    theta = 32'(t);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_c && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_c) begin
      check_eq("accept_timeout", 0, 1);
    end else begin
      a = $itor(t) * PI / 2147483648.0;
      e.m = m;
      e.t = t;
      e.xc = clamp($itor(m) * $cos(a));
      e.yc = clamp($itor(m) * $sin(a));
      e.xn = clamp(kgain * $itor(m) * $cos(a));
      e.yn = clamp(kgain * $itor(m) * $sin(a));
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mag = 16'($urandom);
    theta = 32'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Ready driver for the random phase only
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: checks each result once on first appearance, then hold and pop on handshake
  initial begin
    bit seen;
    int hx, hy;
    exp_t e;
    seen = 1'b0;
    hx = 0;
    hy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        if (out_valid_c && !seen) begin
          seen = 1'b1;
          hx = int'(x_c);
          hy = int'(y_c);
          if (sb.size() == 0) begin
            check_eq("spurious_out_valid", 1, 0);
          end else begin
            e = sb[0];
            check_eq("latency", cyc - e.acc, 17);
            check_near($sformatf("x_comp m=%0d t=%h", e.m, e.t), int'(x_c), e.xc, 4.0);
            check_near($sformatf("y_comp m=%0d t=%h", e.m, e.t), int'(y_c), e.yc, 4.0);
            check_eq("raw_valid", int'(out_valid_n), 1);
            check_near($sformatf("x_raw m=%0d t=%h", e.m, e.t), int'(x_n), e.xn, 6.0);
            check_near($sformatf("y_raw m=%0d t=%h", e.m, e.t), int'(y_n), e.yn, 6.0);
          end
        end
        if (out_valid_c && out_ready) begin
          check_eq("hold_stable", int'((int'(x_c) == hx) && (int'(y_c) == hy)), 1);
          if (sb.size() > 0) void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int dm[9];
    int dt[9];
    int hx, hy, n, cnt;

    for (int i = 0; i < 16; i++) kgain = kgain * $sqrt(1.0 + 1.0 / (4.0 ** i));

    dm = '{16384, 16384, 16384, 16384, 16384, 32767, -32768, 16384, 0};
    dt = '{32'h0000_0000, 32'h4000_0000, 32'h2000_0000, 32'h8000_0000, 32'hA000_0000,
           32'h0000_0000, 32'h0000_0000, 32'hC000_0000, 32'h1234_5678};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", int'(out_valid_c), 0);
    check_eq("rst_x", int'(x_c), 0);
    check_eq("rst_y", int'(y_c), 0);
    check_eq("rst_in_ready", int'(in_ready_c), 1);
    @(posedge clk);
    #1;

    rdy_mode = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(dm[i], dt[i]);
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      send(int'($signed(16'($urandom))), int'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 1;
    out_ready = 1'b1;
    drain();

    // Backpressure then back-to-back accept on release
    rdy_mode = 2;
    out_ready = 1'b0;
    send(16384, 32'h2000_0000);
    n = 0;
    @(negedge clk);
    while (!out_valid_c && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_result_seen", int'(out_valid_c), 1);
    hx = int'(x_c);
    hy = int'(y_c);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_hold", int'(!in_ready_c && out_valid_c && (int'(x_c) == hx) && (int'(y_c) == hy)), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rdy_mode = 1;
    send(-20000, 32'h7000_0000);
    @(negedge clk);
    check_eq("bp_fall_valid", int'(out_valid_c), 0);
    check_eq("bp_run_in_ready", int'(in_ready_c), 0);
    drain();

    // Reset at RUN iteration 5 discards the operation
    send(12345, 32'h1000_0000);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("abort_out_valid", int'(out_valid_c), 0);
    check_eq("abort_in_ready", int'(in_ready_c), 1);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid_c) cnt++;
    end
    check_eq("abort_silent", cnt, 0);
    @(posedge clk);
    #1;
    send(-16384, 32'h6000_0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
